// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential forward AES MixColumns engine.
// Accepts one 128-bit state, transforms COLS_PER_CYCLE columns per clock in
// place, then holds the result on a valid/ready output until it is taken.
// Optional build macro MIX_COLUMNS_SEQ_INV_EN adds an in_inv input that
// selects the inverse MixColumns matrix for the whole transaction.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
`ifdef MIX_COLUMNS_SEQ_INV_EN
    input  logic         in_inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter step and the counter value on the cycle that touches column 3.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [0:127] state_q, state_d;
    logic [0:127] out_data_q, out_data_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [0:127] processed;
    logic [1:0]   col_idx;

`ifdef MIX_COLUMNS_SEQ_INV_EN
    logic inv_q, inv_d;
`else
    logic inv_q;
    assign inv_q = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Inverse coefficients built from x2, x4, x8 multiples of b.
    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // One column: a0 is the top row byte (most significant in the slice).
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        if (inv) begin
            r0 = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
            r1 = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
            r2 = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
            r3 = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
        end else begin
            r0 = xtime(a0) ^ mul3(a1)  ^ a2        ^ a3;
            r1 = a0        ^ xtime(a1) ^ mul3(a2)  ^ a3;
            r2 = a0        ^ a1        ^ xtime(a2) ^ mul3(a3);
            r3 = mul3(a0)  ^ a1        ^ a2        ^ xtime(a3);
        end
        return {r0, r1, r2, r3};
    endfunction

    // State register: all flops return to idle/zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
`ifdef MIX_COLUMNS_SEQ_INV_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
`ifdef MIX_COLUMNS_SEQ_INV_EN
            inv_q      <= inv_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, sweep columns in BUSY, hold in DONE.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: if (in_valid) fsm_d = BUSY;
            BUSY: if (cnt_q == LAST_CNT) fsm_d = DONE;
            DONE: if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Output decode straight from the FSM state.
    always_comb begin
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
        busy      = (fsm_q != IDLE);
    end

    // Datapath: transform the current column group in place and latch the result.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        processed  = state_q;
        col_idx    = cnt_q;
`ifdef MIX_COLUMNS_SEQ_INV_EN
        inv_d      = inv_q;
`endif
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col_idx = cnt_q + 2'(j);
            processed[32*int'(col_idx) +: 32] = mix_column(state_q[32*int'(col_idx) +: 32], inv_q);
        end
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data;
                    cnt_d   = '0;
`ifdef MIX_COLUMNS_SEQ_INV_EN
                    inv_d   = in_inv;
`endif
                end
            end
            BUSY: begin
                state_d = processed;
                if (cnt_q == LAST_CNT) begin
                    cnt_d      = '0;
                    out_data_d = processed;
                end else begin
                    cnt_d = cnt_q + CNT_STEP;
                end
            end
            default: ;
        endcase
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: self-checking bench for mix_columns_seq.
// Expected states are queued at input acceptance and compared as outputs
// appear. Define MIX_COLUMNS_SEQ_INV_EN to also exercise the inverse path.
module tb_mix_columns_seq;

    localparam int COLS = 1;
    localparam int LAT  = 4 / COLS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] out_data;
    logic         busy;
`ifdef MIX_COLUMNS_SEQ_INV_EN
    logic         in_inv = 1'b0;
`endif

    int n_compared = 0;
    int n_mismatched = 0;
    int cycle = 0;
    logic [0:127] exp_q[$];

    mix_columns_seq #(.COLS_PER_CYCLE(COLS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef MIX_COLUMNS_SEQ_INV_EN
        .in_inv(in_inv),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    // Free-running clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Shift-and-add GF(2^8) multiply followed by polynomial reduction.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // Forward MixColumns as a circulant matrix product.
    function automatic logic [0:127] model(input logic [0:127] s);
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [0:127] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], s[(32*c + 8*j) +: 8]);
                res[(32*c + 8*r) +: 8] = acc;
            end
        return res;
    endfunction

    function automatic logic [0:127] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer a state until accepted (bounded); queue its expected result.
    task automatic send_state(input logic [0:127] d, input logic [0:127] e,
                              output bit ok, output int acc_cyc);
        ok = 1'b0;
        acc_cyc = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                acc_cyc = cycle;
                ok = 1'b1;
                exp_q.push_back(e);
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid and capture the output; out_ready set by caller.
    task automatic wait_output(output bit ok, output logic [0:127] data, output int out_cyc);
        ok = 1'b0;
        data = '0;
        out_cyc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (out_valid) begin
                data = out_data;
                out_cyc = cycle;
                ok = 1'b1;
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    function automatic logic [0:127] pop_expected();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        #2;
        n_compared++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
        end
        n_compared++;
        if (out_data !== 128'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out_data: got %h required 0", out_data);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_compared++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 128'h0) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_idle: got flags=%b data=%h required 100 / 0", {in_ready, out_valid, busy}, out_data);
        end
    endtask

    task automatic test_fips();
        bit ok, got;
        int acc_cyc, out_cyc;
        logic [0:127] data, e;
        out_ready = 1'b1;
        send_state(128'hdb135345_f20a225c_01010101_c6c6c6c6,
                   128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, ok, acc_cyc);
        n_compared++;
        if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fips_accept: got ok=%0d busy=%b in_ready=%b required 1 1 0", ok, busy, in_ready);
        end
        wait_output(got, data, out_cyc);
        e = pop_expected();
        n_compared++;
        if (!got || data !== e) begin
            n_mismatched++;
            $display("[TB] FAIL fips_data: got %h (valid seen %0d) required %h", data, got, e);
        end
        n_compared++;
        if (out_cyc - acc_cyc !== LAT) begin
            n_mismatched++;
            $display("[TB] FAIL fips_latency: got %0d edges required %0d", out_cyc - acc_cyc, LAT);
        end
        n_compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL fips_return_idle: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_edge_columns();
        bit ok, got;
        int acc_cyc, out_cyc;
        logic [0:127] data, e;
        out_ready = 1'b1;
        send_state(128'hd4d4d4d5_2d26314c_00000000_ffffffff,
                   128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, ok, acc_cyc);
        wait_output(got, data, out_cyc);
        e = pop_expected();
        n_compared++;
        if (!ok || !got || data !== e) begin
            n_mismatched++;
            $display("[TB] FAIL edge_columns: got %h (acc %0d valid %0d) required %h", data, ok, got, e);
        end
    endtask

    task automatic test_backpressure();
        bit ok, seen;
        int acc_cyc, out_cyc;
        logic [0:127] a, b, first, data, e;
        a = rand_state();
        b = rand_state();
        out_ready = 1'b0;
        send_state(a, model(a), ok, acc_cyc);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_compared++;
        if (!ok || !seen) begin
            n_mismatched++;
            $display("[TB] FAIL bp_reach_done: got acc=%0d valid=%0d required 1 1", ok, seen);
        end
        first = pop_expected();
        in_valid = 1'b1;
        in_data = b;
        for (int k = 0; k < 10; k++) begin
            n_compared++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== first) begin
                n_mismatched++;
                $display("[TB] FAIL bp_hold_%0d: got valid=%b in_ready=%b data=%h required 1 0 %h", k, out_valid, in_ready, out_data, first);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== first) begin
            n_mismatched++;
            $display("[TB] FAIL bp_release: got valid=%b in_ready=%b data=%h required 0 1 %h", out_valid, in_ready, out_data, first);
        end
        send_state(b, model(b), ok, acc_cyc);
        wait_output(seen, data, out_cyc);
        e = pop_expected();
        n_compared++;
        if (!ok || !seen || data !== e) begin
            n_mismatched++;
            $display("[TB] FAIL bp_next_state: got %h (acc %0d valid %0d) required %h", data, ok, seen, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:127] st [3];
        logic [0:127] got_data [3];
        int out_cyc [3];
        bit out_ok [3];
        bit in_ok [3];
        logic [0:127] e;
        for (int k = 0; k < 3; k++) st[k] = rand_state();
        out_ready = 1'b1;
        fork
            begin
                int acc;
                bit ok;
                for (int k = 0; k < 3; k++) begin
                    send_state(st[k], model(st[k]), ok, acc);
                    in_ok[k] = ok;
                end
            end
            begin
                bit ok;
                int oc;
                logic [0:127] d;
                for (int m = 0; m < 3; m++) begin
                    wait_output(ok, d, oc);
                    out_ok[m] = ok;
                    got_data[m] = d;
                    out_cyc[m] = oc;
                end
            end
        join
        for (int k = 0; k < 3; k++) begin
            e = pop_expected();
            n_compared++;
            if (!in_ok[k] || !out_ok[k] || got_data[k] !== e) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_data_%0d: got %h (acc %0d valid %0d) required %h", k, got_data[k], in_ok[k], out_ok[k], e);
            end
        end
        for (int k = 1; k < 3; k++) begin
            n_compared++;
            if (out_cyc[k] - out_cyc[k-1] !== LAT + 2) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_interval_%0d: got %0d cycles required %0d", k, out_cyc[k] - out_cyc[k-1], LAT + 2);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        bit ok, got;
        int acc_cyc, out_cyc;
        logic [0:127] x, data, e;
        x = rand_state();
        out_ready = 1'b1;
        send_state(x, model(x), ok, acc_cyc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_compared++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 128'h0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_state: got flags=%b data=%h required 100 / 0", {in_ready, out_valid, busy}, out_data);
        end
        @(posedge clk); #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_nothing_emitted: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        send_state(128'hdb135345_f20a225c_01010101_c6c6c6c6,
                   128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, ok, acc_cyc);
        wait_output(got, data, out_cyc);
        e = pop_expected();
        n_compared++;
        if (!ok || !got || data !== e) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_recover: got %h (acc %0d valid %0d) required %h", data, ok, got, e);
        end
    endtask

`ifdef MIX_COLUMNS_SEQ_INV_EN
    task automatic test_inverse();
        bit ok, got;
        int acc_cyc, out_cyc;
        logic [0:127] data, e;
        out_ready = 1'b1;
        in_inv = 1'b1;
        send_state(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                   128'hdb135345_f20a225c_01010101_c6c6c6c6, ok, acc_cyc);
        in_inv = 1'b0;
        wait_output(got, data, out_cyc);
        e = pop_expected();
        n_compared++;
        if (!ok || !got || data !== e) begin
            n_mismatched++;
            $display("[TB] FAIL inverse_data: got %h (acc %0d valid %0d) required %h", data, ok, got, e);
        end
        n_compared++;
        if (out_cyc - acc_cyc !== LAT) begin
            n_mismatched++;
            $display("[TB] FAIL inverse_latency: got %0d edges required %0d", out_cyc - acc_cyc, LAT);
        end
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_fips();
        test_edge_columns();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef MIX_COLUMNS_SEQ_INV_EN
        test_inverse();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
